// File: rtl/rc4_ksa_engine.sv
// -----------------------------------------------------------------------------
// rc4_ksa_engine
//
// Self-contained RC4 key-scheduling loop. On start it optionally writes the
// identity permutation into the S-box RAM and then performs the full
// key-scheduling shuffle over every address, driving a single-port RAM with
// a one-cycle registered read. A one-cycle done pulse marks a permutation
// that is ready for the PRGA stage.
//
// Parameters:
//   ADDR_W    - S-box address width, depth N = 2**ADDR_W
//   DATA_W    - S-box word width (must be >= ADDR_W)
//   KEY_BYTES - key length in DATA_W-bit words
//
// Ports:
//   clk      in   single clock, rising edge
//   reset    in   asynchronous, active-low reset
//   start    in   run request, sampled only in IDLE
//   init_en  in   sampled with start; 1 = write identity before shuffling
//   key      in   secret key, word 0 in the most significant position
//   s_addr   out  RAM address
//   s_wdata  out  RAM write data
//   s_wren   out  RAM write enable
//   s_rdata  in   RAM read data for the address presented one cycle earlier
//   busy     out  high from the cycle after start until the last write
//   done     out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module rc4_ksa_engine #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int KEY_BYTES = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        init_en,
  input  logic [KEY_BYTES*DATA_W-1:0] key,
  output logic [ADDR_W-1:0]           s_addr,
  output logic [DATA_W-1:0]           s_wdata,
  output logic                        s_wren,
  input  logic [DATA_W-1:0]           s_rdata,
  output logic                        busy,
  output logic                        done
);

  // Key word index is tracked by its own wrapping counter instead of
  // computing i mod KEY_BYTES, so non-power-of-two key lengths cost nothing.
  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int KSEL_N = 1 << KIDX_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [KIDX_W-1:0] LAST_KIDX = KIDX_W'(KEY_BYTES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_RD_I,
    S_GET_I,
    S_RD_J,
    S_GET_J,
    S_WR_I,
    S_WR_J,
    S_DONE
  } state_t;

  state_t                        r_state;
  state_t                        w_state_next;
  logic [ADDR_W-1:0]             r_i;
  logic [ADDR_W-1:0]             r_j;
  logic [ADDR_W-1:0]             r_k;
  logic [DATA_W-1:0]             r_si;
  logic [DATA_W-1:0]             r_sj;
  logic [KEY_BYTES*DATA_W-1:0]   r_key;
  logic [KIDX_W-1:0]             r_kidx;
  logic [DATA_W-1:0]             w_key_word [KSEL_N];
  logic [ADDR_W-1:0]             w_j_next;

  // Split the captured key into words; unused selector slots read as zero
  // so the mux index never falls outside the array.
  genvar gi;
  generate
    for (gi = 0; gi < KSEL_N; gi++) begin : g_key_word
      if (gi < KEY_BYTES) begin : g_used
        assign w_key_word[gi] = r_key[(KEY_BYTES-1-gi)*DATA_W +: DATA_W];
      end else begin : g_pad
        assign w_key_word[gi] = '0;
      end
    end
  endgenerate

  // j + S[i] + key word, truncated to the address width.
  assign w_j_next = ADDR_W'(DATA_W'(r_j) + s_rdata + w_key_word[r_kidx]);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and RAM/handshake outputs
  always_comb begin
    w_state_next = r_state;
    s_addr       = '0;
    s_wdata      = '0;
    s_wren       = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_next = init_en ? S_INIT : S_RD_I;
        end
      end
      S_INIT: begin
        s_addr  = r_k;
        s_wdata = DATA_W'(r_k);
        s_wren  = 1'b1;
        if (r_k == LAST_ADDR) begin
          w_state_next = S_RD_I;
        end
      end
      S_RD_I: begin
        s_addr       = r_i;
        w_state_next = S_GET_I;
      end
      S_GET_I: begin
        w_state_next = S_RD_J;
      end
      S_RD_J: begin
        s_addr       = r_j;
        w_state_next = S_GET_J;
      end
      S_GET_J: begin
        w_state_next = S_WR_I;
      end
      S_WR_I: begin
        s_addr       = r_i;
        s_wdata      = r_sj;
        s_wren       = 1'b1;
        w_state_next = S_WR_J;
      end
      S_WR_J: begin
        // When i == j both writes carry the same word, leaving RAM unchanged.
        s_addr       = r_j;
        s_wdata      = r_si;
        s_wren       = 1'b1;
        w_state_next = (r_i == LAST_ADDR) ? S_DONE : S_RD_I;
      end
      S_DONE: begin
        busy         = 1'b0;
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        busy         = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_i    <= '0;
      r_j    <= '0;
      r_k    <= '0;
      r_si   <= '0;
      r_sj   <= '0;
      r_key  <= '0;
      r_kidx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_key  <= key;
            r_i    <= '0;
            r_j    <= '0;
            r_k    <= '0;
            r_kidx <= '0;
          end
        end
        S_INIT: begin
          r_k <= r_k + 1'b1;
        end
        S_GET_I: begin
          r_si <= s_rdata;
          r_j  <= w_j_next;
        end
        S_GET_J: begin
          r_sj <= s_rdata;
        end
        S_WR_J: begin
          if (r_i != LAST_ADDR) begin
            r_i    <= r_i + 1'b1;
            r_kidx <= (r_kidx == LAST_KIDX) ? '0 : r_kidx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
module tb_rc4_ksa_engine;

  logic clk = 1'b0;
  logic reset;

  // Default-parameter instance (N=256, KEY_BYTES=3)
  logic        start, init_en;
  logic [23:0] key;
  logic [7:0]  s_addr, s_wdata, s_rdata;
  logic        s_wren, busy, done;

  // Small instance (N=4, KEY_BYTES=1)
  logic        sm_start, sm_init_en;
  logic [7:0]  sm_key;
  logic [1:0]  sm_addr;
  logic [7:0]  sm_wdata, sm_rdata;
  logic        sm_wren, sm_busy, sm_done;

  always #5 clk = ~clk;

  rc4_ksa_engine #(.ADDR_W(8), .DATA_W(8), .KEY_BYTES(3)) u_dut (
    .clk(clk), .reset(reset), .start(start), .init_en(init_en), .key(key),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren), .s_rdata(s_rdata),
    .busy(busy), .done(done)
  );

  rc4_ksa_engine #(.ADDR_W(2), .DATA_W(8), .KEY_BYTES(1)) u_small (
    .clk(clk), .reset(reset), .start(sm_start), .init_en(sm_init_en), .key(sm_key),
    .s_addr(sm_addr), .s_wdata(sm_wdata), .s_wren(sm_wren), .s_rdata(sm_rdata),
    .busy(sm_busy), .done(sm_done)
  );

  // RAM models with registered read; fill_req loads identity or a junk pattern
  logic [7:0] mem [256];
  logic [7:0] sm_mem [4];
  logic       fill_req, fill_ident;

  always @(posedge clk) begin
    if (fill_req) begin
      for (int a = 0; a < 256; a++) mem[a] <= fill_ident ? 8'(a) : (8'(a * 37 + 11) ^ 8'hA5);
    end else if (s_wren) begin
      mem[s_addr] <= s_wdata;
    end
    s_rdata <= mem[s_addr];
  end

  always @(posedge clk) begin
    if (sm_wren) sm_mem[sm_addr] <= sm_wdata;
    sm_rdata <= sm_mem[sm_addr];
  end

  // Write loggers, sampled mid-cycle
  int         wcount = 0;
  int         sm_wcount = 0;
  logic [7:0] wlog_a [16384];
  logic [7:0] wlog_d [16384];
  logic [1:0] sm_wlog_a [64];

  always @(negedge clk) begin
    if (s_wren) begin
      if (wcount < 16384) begin
        wlog_a[wcount] = s_addr;
        wlog_d[wcount] = s_wdata;
      end
      wcount++;
    end
    if (sm_wren) begin
      if (sm_wcount < 64) sm_wlog_a[sm_wcount] = sm_addr;
      sm_wcount++;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Reference software KSA from the identity permutation
  logic [7:0] exp_s [256];

  task automatic model_ksa(input logic [23:0] k);
    logic [7:0] kb [3];
    logic [7:0] j;
    logic [7:0] t;
    kb[0] = k[23:16];
    kb[1] = k[15:8];
    kb[2] = k[7:0];
    for (int a = 0; a < 256; a++) exp_s[a] = 8'(a);
    j = 8'd0;
    for (int a = 0; a < 256; a++) begin
      j = j + exp_s[a] + kb[a % 3];
      t = exp_s[a];
      exp_s[a] = exp_s[j];
      exp_s[j] = t;
    end
  endtask

  task automatic check_ram(input string name);
    int bad = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== exp_s[a]) bad++;
    check(name, 64'(bad), 64'd0);
  endtask

  task automatic fill(input bit ident);
    @(negedge clk);
    fill_ident = ident;
    fill_req   = 1'b1;
    @(negedge clk);
    fill_req   = 1'b0;
  endtask

  // Starts a run on the default instance; lat = edges after T until done is seen.
  task automatic run_dut(input bit ini, input logic [23:0] k, input bit hold, input bit scramble,
                         output int lat, output int wr, output bit busy_ok, output int wb);
    int n;
    @(negedge clk);
    wb      = wcount;
    start   = 1'b1;
    init_en = ini;
    key     = k;
    @(posedge clk);
    #1;
    busy_ok = busy;
    if (!hold) start = 1'b0;
    if (scramble) begin
      key     = ~k;
      init_en = ~ini;
    end
    lat = -1;
    n   = 0;
    while (n < 4000 && lat < 0) begin
      @(posedge clk);
      n++;
      #1;
      if (done) begin
        lat = n;
        if (busy) busy_ok = 1'b0;
      end else if (!busy) begin
        busy_ok = 1'b0;
      end
    end
    @(negedge clk);
    wr = wcount - wb;
  endtask

  typedef struct {
    bit          init;
    logic [23:0] key;
    bit          fill_identity;
    bit          scramble;
    int          exp_lat;
    int          exp_wr;
    bit          chk_ij;
  } vec_t;

  vec_t vt [4];

  initial begin
    int         lat, wr, wb, lat2, n, idx;
    bit         bok;
    logic [7:0] sm_exp [4];
    logic [1:0] sm_jexp [4];

    // key 0x00007B makes j land on 5 at i=5 (S[5] still 5 there)
    vt[0] = '{1'b1, 24'h000249, 1'b0, 1'b1, 1792, 768, 1'b0};
    vt[1] = '{1'b0, 24'h000249, 1'b1, 1'b0, 1536, 512, 1'b0};
    vt[2] = '{1'b1, 24'h00007B, 1'b0, 1'b0, 1792, 768, 1'b1};
    vt[3] = '{1'b0, 24'hC0FFEE, 1'b1, 1'b1, 1536, 512, 1'b0};

    sm_exp[0] = 8'd0; sm_exp[1] = 8'd2; sm_exp[2] = 8'd3; sm_exp[3] = 8'd1;
    sm_jexp[0] = 2'd1; sm_jexp[1] = 2'd2; sm_jexp[2] = 2'd3; sm_jexp[3] = 2'd0;

    reset = 1'b0; start = 1'b0; init_en = 1'b0; key = '0;
    sm_start = 1'b0; sm_init_en = 1'b0; sm_key = '0;
    fill_req = 1'b0; fill_ident = 1'b0;
    #2;
    check("reset_outputs", 64'({s_addr, s_wdata, s_wren, busy, done}), 64'd0);
    check("reset_outputs_small", 64'({sm_addr, sm_wdata, sm_wren, sm_busy, sm_done}), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Small case: N=4, key=0x01, with init
    @(negedge clk);
    wb = sm_wcount;
    sm_start = 1'b1; sm_init_en = 1'b1; sm_key = 8'h01;
    @(posedge clk);
    #1;
    sm_start = 1'b0;
    lat = -1; n = 0;
    while (n < 100 && lat < 0) begin
      @(posedge clk);
      n++;
      #1;
      if (sm_done) lat = n;
    end
    @(negedge clk);
    check("small_latency", 64'(lat), 64'd28);
    check("small_writes", 64'(sm_wcount - wb), 64'd12);
    for (int a = 0; a < 4; a++) check($sformatf("small_ram[%0d]", a), 64'(sm_mem[a]), 64'(sm_exp[a]));
    for (int i = 0; i < 4; i++) check($sformatf("small_j[%0d]", i), 64'(sm_wlog_a[wb + 4 + 2*i + 1]), 64'(sm_jexp[i]));

    // Table-driven runs on the default instance
    for (int v = 0; v < 4; v++) begin
      fill(vt[v].fill_identity);
      model_ksa(vt[v].key);
      run_dut(vt[v].init, vt[v].key, 1'b0, vt[v].scramble, lat, wr, bok, wb);
      check($sformatf("v%0d_latency", v), 64'(lat), 64'(vt[v].exp_lat));
      check($sformatf("v%0d_writes", v), 64'(wr), 64'(vt[v].exp_wr));
      check($sformatf("v%0d_busy_window", v), 64'(bok), 64'd1);
      check_ram($sformatf("v%0d_ram_bad_entries", v));
      if (vt[v].chk_ij) begin
        idx = wb + (vt[v].init ? 256 : 0) + 10;
        check("ij_wr_i_addr", 64'(wlog_a[idx]), 64'd5);
        check("ij_wr_j_addr", 64'(wlog_a[idx + 1]), 64'd5);
        check("ij_wr_i_data", 64'(wlog_d[idx]), 64'd5);
        check("ij_wr_j_data", 64'(wlog_d[idx + 1]), 64'd5);
      end
    end

    // Reset at T+700 mid-run
    fill(1'b0);
    @(negedge clk);
    start = 1'b1; init_en = 1'b1; key = 24'h000249;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (700) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("midrun_reset_outputs", 64'({s_addr, s_wdata, s_wren, busy, done}), 64'd0);
    wb = wcount;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("writes_after_reset", 64'(wcount - wb), 64'd0);

    // Fresh start after reset
    model_ksa(24'h000249);
    run_dut(1'b1, 24'h000249, 1'b0, 1'b0, lat, wr, bok, wb);
    check("post_reset_latency", 64'(lat), 64'd1792);
    check_ram("post_reset_ram_bad_entries");

    // start held high for the whole run
    fill(1'b1);
    run_dut(1'b0, 24'h000249, 1'b1, 1'b0, lat, wr, bok, wb);
    check("held_latency", 64'(lat), 64'd1536);
    check_ram("held_ram_bad_entries");
    @(posedge clk);
    #1;
    check("held_busy_after_done", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    check("held_busy_restart", 64'(busy), 64'd1);
    start = 1'b0;
    lat2 = -1; n = 0;
    while (n < 2000 && lat2 < 0) begin
      @(posedge clk);
      n++;
      #1;
      if (done) lat2 = n;
    end
    check("held_second_latency", 64'(lat2), 64'd1536);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
